tmr_scrub_register: RTL
=======================

# tmr_scrub_register

K-modular redundant storage register with periodic scrubbing: the write side that pairs with the majority voter. It holds K_MMR copies of a WIDTH-bit value and presents the bitwise-voted word. A scrub engine periodically rewrites the voted value into every copy, so single-event upsets are repaired instead of accumulating. Used for configuration and status registers in the radiation-exposed readout logic.

## Interface
- K_MMR, 3: number of redundant copies; legal values are 3 and 5 only. Any other value is a static elaboration error.
- WIDTH, 16: register width in bits, 1..64.
- RESET_VALUE, '0: value loaded into every copy on reset.
- SCRUB_PERIOD, 1024: cycles between automatic scrubs. 0 disables the timer.
- CNT_WIDTH, 16: width of the correction counter.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_en_i  in  1  write strobe; loads wr_data_i into all copies.
- wr_data_i  in  WIDTH  write data.
- rd_data_o  out  WIDTH  bitwise majority vote of the copies (combinational from the copy registers).
- mismatch_o  out  1  combinational; high when any bit of any copy differs from the voted word.
- scrub_req_i  in  1  request an immediate scrub.
- scrub_busy_o  out  1  high while the engine is in CHECK or REPAIR.
- corrected_o  out  1  one-cycle pulse when a repair is written.
- err_count_o  out  CNT_WIDTH  saturating count of scrubs that found a mismatch.
- err_count_clr_i  in  1  synchronous clear of err_count_o.
- inj_en_i  in  1  fault injection strobe (verification only).
- inj_copy_i  in  $clog2(K_MMR)  copy to corrupt. Out-of-range values inject nothing.
- inj_bit_i  in  $clog2(WIDTH)  bit to invert. Out-of-range values inject nothing.

## Operation
- Voting is per bit. For K=3 a bit is 1 when at least 2 copies are 1; for K=5, when at least 3 are.
- FSM states:
  - IDLE: scrub_busy_o=0. Moves to CHECK on a scrub trigger.
  - CHECK: compares each copy with the voted word. Goes to REPAIR if any copy differs, otherwise to IDLE.
  - REPAIR: writes the current voted word into all copies, increments err_count_o, pulses corrected_o, then returns to IDLE.
- Scrub trigger is scrub_req_i, or the timer terminal count while in IDLE.
  - Timer counts 0..SCRUB_PERIOD-1 and wraps.
  - A terminal count or scrub_req_i arriving while busy sets a single pending flag. The pending flag starts a scrub on the first IDLE cycle. Further triggers while pending is set are merged into it.
- Priority per cycle is write > repair > injection. A lower-priority update in the same cycle is dropped.
- Write during REPAIR: the write is stored, corrected_o stays 0, and err_count_o still increments because a mismatch was detected.
- Injection inverts one bit of one copy only.
- err_count_o saturates at all-ones.
  - err_count_clr_i alone sets the count to 0.
  - Clear together with an increment gives a count of 1.
- Reset values:
  - All copies = RESET_VALUE, so rd_data_o=RESET_VALUE.
  - mismatch_o=0, scrub_busy_o=0, corrected_o=0, err_count_o=0.
  - State = IDLE, timer = 0, pending = 0.
- Reset asserted mid-scrub aborts the scrub immediately. No repair or count update occurs.

## Timing
- Write at cycle n: rd_data_o shows the new value from n+1.
- Injection at cycle n: mismatch_o goes high from n+1; rd_data_o is unchanged.
- Scrub trigger at n (IDLE):
  - CHECK at n+1, with scrub_busy_o=1.
  - If a mismatch is found: REPAIR at n+2 with corrected_o=1. Copies are equal from n+3, mismatch_o=0 from n+3, and err_count_o is incremented from n+3.
  - If no mismatch: IDLE at n+2.
- The timer keeps counting during a scrub.
- With SCRUB_PERIOD=P and no other activity, a scrub starts every P cycles.
- Throughput: at most one scrub per 2 cycles (clean) or 3 cycles (repair).

## Test plan
- Reset, then write 0xA5A5 -> rd_data_o=0xA5A5 next cycle, mismatch_o=0, err_count_o=0.
- Inject copy 1, bit 3 -> mismatch_o=1 and rd_data_o still 0xA5A5. Then scrub_req_i -> corrected_o pulse 2 cycles later, mismatch_o=0, err_count_o=1.
- K=5: inject copies 0 and 4 at bit 0 -> voted value unchanged. Scrub repairs both copies; err_count_o increments by exactly 1.
- Write 0x1234 in the REPAIR cycle -> all copies=0x1234, corrected_o=0, err_count_o incremented.
- SCRUB_PERIOD=8 with repeated injections -> scrubs every 8 cycles. A scrub_req_i while busy yields exactly one extra scrub.
- Force err_count_o to all-ones with CNT_WIDTH=4, then repair -> count stays 15. Clear together with a repair -> count=1. Reset mid-CHECK -> all outputs at reset values.

Source files
------------

// File: rtl/tmr_scrub_register.sv
// tmr_scrub_register: K-modular redundant register with a scrub engine.
//
// Keeps K_MMR copies of a WIDTH-bit value and presents the bitwise majority vote.
// A scrub (from scrub_req_i or the period timer) checks every copy against the vote
// and, on any difference, rewrites the voted word into all copies.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wr_en_i, wr_data_i    write strobe / data, loads all copies
//   rd_data_o             majority-voted word
//   mismatch_o            any copy differs from the voted word
//   scrub_req_i           request an immediate scrub
//   scrub_busy_o          engine is in CHECK or REPAIR
//   corrected_o           one-cycle pulse when a repair is written
//   err_count_o           saturating count of scrubs that found a mismatch
//   err_count_clr_i       synchronous clear of err_count_o
//   inj_en_i, inj_copy_i, inj_bit_i  fault injection: invert one bit of one copy
module tmr_scrub_register #(
  parameter int unsigned       K_MMR        = 3,
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
  parameter int unsigned       SCRUB_PERIOD = 1024,
  parameter int unsigned       CNT_WIDTH    = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      wr_en_i,
  input  logic [WIDTH-1:0]                          wr_data_i,
  output logic [WIDTH-1:0]                          rd_data_o,
  output logic                                      mismatch_o,
  input  logic                                      scrub_req_i,
  output logic                                      scrub_busy_o,
  output logic                                      corrected_o,
  output logic [CNT_WIDTH-1:0]                      err_count_o,
  input  logic                                      err_count_clr_i,
  input  logic                                      inj_en_i,
  input  logic [$clog2(K_MMR)-1:0]                  inj_copy_i,
  input  logic [(WIDTH > 1 ? $clog2(WIDTH) : 1)-1:0] inj_bit_i
);

  if (!(K_MMR == 3 || K_MMR == 5)) begin : g_bad_k
    $error("tmr_scrub_register: K_MMR must be 3 or 5");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("tmr_scrub_register: WIDTH must be 1..64");
  end

  localparam int unsigned TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [TW-1:0] TimerLast = (SCRUB_PERIOD == 0) ? '0 : TW'(SCRUB_PERIOD - 1);
  localparam logic [2:0] Maj = 3'((K_MMR + 1) / 2);

  typedef enum logic [1:0] {StIdle, StCheck, StRepair} state_e;

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]      copy_q [K_MMR];
  logic [WIDTH-1:0]      copy_d [K_MMR];

  logic [WIDTH-1:0] voted;
  logic [2:0]       ones;
  logic             diff;
  logic             tc;
  logic             trig;
  logic             repair;
  logic             inj_valid;

  // Per-bit majority vote and copy comparison.
  always_comb begin
    voted = '0;
    ones  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int k = 0; k < K_MMR; k++) begin
        ones = ones + 3'(copy_q[k][b]);
      end
      voted[b] = (ones >= Maj);
    end
    diff = 1'b0;
    for (int k = 0; k < K_MMR; k++) begin
      diff = diff | (copy_q[k] != voted);
    end
  end

  assign rd_data_o    = voted;
  assign mismatch_o   = diff;
  assign scrub_busy_o = (state_q != StIdle);
  assign repair       = (state_q == StRepair);
  // A write in the REPAIR cycle overrides the repair data, so no correction is reported.
  assign corrected_o  = repair & ~wr_en_i;
  assign err_count_o  = cnt_q;

  assign tc        = (SCRUB_PERIOD != 0) && (timer_q == TimerLast);
  assign trig      = scrub_req_i | tc;
  assign inj_valid = inj_en_i && (32'(inj_copy_i) < K_MMR) && (32'(inj_bit_i) < WIDTH);

  always_comb begin
    // Free-running period timer, independent of the scrub state.
    timer_d = '0;
    if (SCRUB_PERIOD != 0) begin
      timer_d = tc ? '0 : timer_q + 1'b1;
    end

    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      StIdle: begin
        if (trig || pending_q) begin
          state_d   = StCheck;
          pending_d = 1'b0;
        end
      end
      StCheck: begin
        state_d = diff ? StRepair : StIdle;
        if (trig) pending_d = 1'b1;
      end
      StRepair: begin
        state_d = StIdle;
        if (trig) pending_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Write beats repair beats injection; the loser is dropped.
    for (int k = 0; k < K_MMR; k++) begin
      copy_d[k] = copy_q[k];
    end
    if (wr_en_i) begin
      for (int k = 0; k < K_MMR; k++) copy_d[k] = wr_data_i;
    end else if (repair) begin
      for (int k = 0; k < K_MMR; k++) copy_d[k] = voted;
    end else if (inj_valid) begin
      copy_d[inj_copy_i][inj_bit_i] = ~copy_q[inj_copy_i][inj_bit_i];
    end

    cnt_d = cnt_q;
    if (err_count_clr_i) begin
      cnt_d = repair ? CNT_WIDTH'(1) : '0;
    end else if (repair && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      timer_q   <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < K_MMR; k++) copy_q[k] <= RESET_VALUE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < K_MMR; k++) copy_q[k] <= copy_d[k];
    end
  end

endmodule
